// File: rtl/npc_if.sv
// Fetch-sequencer bus: branch/jump requests in, fetch PC and status out.
// Optional exception pins exist only when NPC_EXCEPTION_EN is defined.
interface npc_if;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fetch_req;
  logic        redirect_pending;
`ifdef NPC_EXCEPTION_EN
  logic        exc;
  logic [31:0] epc;
`endif

  // Sequencer side.
  modport master (
`ifdef NPC_EXCEPTION_EN
    input  exc,
    output epc,
`endif
    input  imem_ready,
    input  stall,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_index,
    input  jr,
    input  jr_target,
    output pc,
    output pc4,
    output fetch_req,
    output redirect_pending
  );

  // Pipeline / memory side.
  modport slave (
`ifdef NPC_EXCEPTION_EN
    output exc,
    input  epc,
`endif
    output imem_ready,
    output stall,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_index,
    output jr,
    output jr_target,
    input  pc,
    input  pc4,
    input  fetch_req,
    input  redirect_pending
  );
endinterface

// File: rtl/npc_sequencer.sv
// Next-PC sequencer: BOOT/FETCH/HOLD control, redirect priority and a pending-redirect buffer.
// Exception entry (exc/epc) is compiled in by defining NPC_EXCEPTION_EN.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input logic clk,
  input logic rst,
  npc_if.master bus
);

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic        pend_q;
  logic [31:0] pend_tgt_q;
  logic [31:0] br_off_ext;
  logic [31:0] redir_tgt;
  logic        redirect;
  logic        advance;
  logic [31:0] next_pc;

`ifdef NPC_EXCEPTION_EN
  logic [31:0] epc_q;
`else
  logic [31:0] unused_exc_vector;
  assign unused_exc_vector = EXC_VECTOR;
`endif

  logic [1:0] unused_jr_low;
  assign unused_jr_low = bus.jr_target[1:0];

  assign pc4        = pc_q + 32'd4;
  assign br_off_ext = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign redirect   = bus.jr | bus.jump | bus.branch_taken;
  assign advance    = (state_q == StFetch) & bus.imem_ready & ~bus.stall;

  always_comb begin
    redir_tgt = pc4;
    if (bus.jr) begin
      redir_tgt = {bus.jr_target[31:2], 2'b00};
    end else if (bus.jump) begin
      redir_tgt = {pc4[31:28], bus.jump_index, 2'b00};
    end else if (bus.branch_taken) begin
      redir_tgt = pc4 + br_off_ext;
    end
  end

  // A live redirect beats the buffered one; otherwise fall through sequentially.
  always_comb begin
    next_pc = pc4;
    if (redirect) begin
      next_pc = redir_tgt;
    end else if (pend_q) begin
      next_pc = pend_tgt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = bus.stall ? StHold : StFetch;
      StHold:  state_d = bus.stall ? StHold : StFetch;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
`ifdef NPC_EXCEPTION_EN
      epc_q      <= 32'h0000_0000;
    end else if (bus.exc) begin
      // Exceptions ignore stall and memory readiness.
      state_q    <= StFetch;
      pc_q       <= EXC_VECTOR;
      epc_q      <= pc_q;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
`endif
    end else begin
      state_q <= state_d;
      if (advance) begin
        pc_q   <= next_pc;
        pend_q <= 1'b0;
      end else if (redirect) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= redir_tgt;
      end
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc4              = pc4;
  assign bus.fetch_req        = (state_q == StFetch);
  assign bus.redirect_pending = pend_q;
`ifdef NPC_EXCEPTION_EN
  assign bus.epc              = epc_q;
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed literal checks then randomized traffic
// compared every cycle against a rule-level model of the fetch sequencer.
module tb_npc_sequencer;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] EXV = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  npc_if bus ();

  npc_sequencer #(.RESET_PC(RPC), .EXC_VECTOR(EXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: pc, whether the cycle is the boot cycle, whether fetch is held.
  logic [31:0] m_pc = 32'h0;
  logic        m_boot = 1'b1;
  logic        m_hold = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic        m_valid = 1'b0;

  function automatic logic [31:0] target_of(input logic [31:0] pc);
    logic signed [31:0] soff;
    soff = 32'(signed'(bus.branch_offset));
    if (bus.jr) return bus.jr_target & 32'hFFFF_FFFC;
    if (bus.jump) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, bus.jump_index} << 2);
    return pc + 32'd4 + 32'(soff * 4);
  endfunction

  function automatic logic redir_in();
    return bus.jr | bus.jump | bus.branch_taken;
  endfunction

  function automatic logic advancing();
    return !m_boot && !m_hold && bus.imem_ready && !bus.stall;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= RPC; m_boot <= 1'b1; m_hold <= 1'b0;
      m_pend <= 1'b0; m_ptgt <= 32'h0; m_epc <= 32'h0; m_valid <= 1'b1;
    end
`ifdef NPC_EXCEPTION_EN
    else if (bus.exc) begin
      m_pc <= EXV; m_epc <= m_pc; m_boot <= 1'b0; m_hold <= 1'b0; m_pend <= 1'b0;
    end
`endif
    else begin
      m_boot <= 1'b0;
      m_hold <= m_boot ? 1'b0 : bus.stall;
      if (advancing()) begin
        m_pc   <= redir_in() ? target_of(m_pc) : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend <= 1'b0;
      end else if (redir_in()) begin
        m_pend <= 1'b1;
        m_ptgt <= target_of(m_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pc", bus.pc, m_pc);
      chk("m_pc4", bus.pc4, m_pc + 32'd4);
      chk("m_fetch_req", {31'd0, bus.fetch_req}, {31'd0, !m_boot && !m_hold});
      chk("m_pending", {31'd0, bus.redirect_pending}, {31'd0, m_pend});
`ifdef NPC_EXCEPTION_EN
      chk("m_epc", bus.epc, m_epc);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_ready = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_offset = 16'h0; bus.jump = 1'b0; bus.jump_index = 26'h0;
    bus.jr = 1'b0; bus.jr_target = 32'h0;
`ifdef NPC_EXCEPTION_EN
    bus.exc = 1'b0;
`endif
  endtask

  task automatic setpc(input logic [31:0] a);
    idle();
    bus.jr = 1'b1; bus.jr_target = a;
    cyc();
    chk("setpc", bus.pc, a);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    chk("rst_pc", bus.pc, RPC);
    chk("rst_fetch", {31'd0, bus.fetch_req}, 32'd0);
    chk("rst_pend", {31'd0, bus.redirect_pending}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("boot_pc", bus.pc, 32'h0000_3000);
    chk("boot_fetch_on", {31'd0, bus.fetch_req}, 32'd1);
    cyc();
    chk("seq_3004", bus.pc, 32'h0000_3004);
    cyc();
    chk("seq_3008", bus.pc, 32'h0000_3008);

    setpc(32'h0000_3010);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFC;
    cyc();
    chk("br_neg", bus.pc, 32'h0000_3004);
    setpc(32'h0000_3010);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0003;
    cyc();
    chk("br_pos", bus.pc, 32'h0000_3020);

    setpc(32'h4000_0100);
    bus.jump = 1'b1; bus.jump_index = 26'h0000040;
    cyc();
    chk("jump", bus.pc, 32'h4000_0100);
    bus.jr = 1'b1; bus.jr_target = 32'h0000_1237;
    cyc();
    chk("jr_over_jump", bus.pc, 32'h0000_1234);

    setpc(32'h0000_1FFC);
    bus.imem_ready = 1'b0; bus.branch_taken = 1'b1; bus.branch_offset = 16'h0;
    cyc();
    chk("pend_set", {31'd0, bus.redirect_pending}, 32'd1);
    chk("pend_hold_pc", bus.pc, 32'h0000_1FFC);
    idle();
    cyc();
    chk("pend_taken", bus.pc, 32'h0000_2000);
    chk("pend_clr", {31'd0, bus.redirect_pending}, 32'd0);

    setpc(32'h0000_0008);
    bus.stall = 1'b1;
    cyc();
    chk("hold_fetch", {31'd0, bus.fetch_req}, 32'd0);
    chk("hold_pc", bus.pc, 32'h0000_0008);
    bus.branch_taken = 1'b1;
    cyc();
    chk("hold_pc2", bus.pc, 32'h0000_0008);
    chk("hold_pend", {31'd0, bus.redirect_pending}, 32'd1);
    bus.branch_taken = 1'b0;
    rst = 1'b1;
    cyc();
    chk("hold_rst_pc", bus.pc, RPC);
    chk("hold_rst_fetch", {31'd0, bus.fetch_req}, 32'd0);
    chk("hold_rst_pend", {31'd0, bus.redirect_pending}, 32'd0);
    rst = 1'b0; idle();
    cyc();

`ifdef NPC_EXCEPTION_EN
    setpc(32'h0000_0040);
    bus.imem_ready = 1'b0; bus.branch_taken = 1'b1;
    cyc();
    bus.branch_taken = 1'b0; bus.stall = 1'b1; bus.exc = 1'b1;
    cyc();
    chk("exc_pc", bus.pc, 32'h0000_0080);
    chk("exc_epc", bus.epc, 32'h0000_0040);
    chk("exc_pend", {31'd0, bus.redirect_pending}, 32'd0);
    chk("exc_fetch", {31'd0, bus.fetch_req}, 32'd1);
    idle();
`endif

    setpc(32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc4, 32'h0000_0000);
    cyc();
    chk("wrap_pc", bus.pc, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.branch_taken = ($urandom_range(0, 6) == 0);
      bus.branch_offset = 16'($urandom);
      bus.jump = ($urandom_range(0, 6) == 0);
      bus.jump_index = 26'($urandom);
      bus.jr = ($urandom_range(0, 6) == 0);
      bus.jr_target = $urandom;
`ifdef NPC_EXCEPTION_EN
      bus.exc = ($urandom_range(0, 40) == 0);
`endif
      cyc();
    end
    rst = 1'b0; idle();
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
